// File: rtl/writeback_stage_ld_if.sv
// Memory-to-writeback bundle: M-stage request, load response and W-stage results.
// slave = writeback stage, master = the surrounding pipeline/bench.
interface writeback_stage_ld_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  valid_m;
  logic                  ready_w;
  logic                  RegWriteM;
  logic [REG_ADDR_W-1:0] RdM;
  logic [1:0]            ResultSrcM;
  logic [2:0]            funct3M;
  logic [XLEN-1:0]       ALU_ResultM;
  logic [XLEN-1:0]       PCPlus4M;
  logic [XLEN-1:0]       ImmExtM;
  logic                  mem_rvalid;
  logic [XLEN-1:0]       mem_rdata;
  logic                  RegWriteW;
  logic [REG_ADDR_W-1:0] RdW;
  logic [XLEN-1:0]       ResultW;
  logic [63:0]           retire_count;

  modport slave (
    input  valid_m, RegWriteM, RdM, ResultSrcM, funct3M, ALU_ResultM,
           PCPlus4M, ImmExtM, mem_rvalid, mem_rdata,
    output ready_w, RegWriteW, RdW, ResultW, retire_count
  );

  modport master (
    output valid_m, RegWriteM, RdM, ResultSrcM, funct3M, ALU_ResultM,
           PCPlus4M, ImmExtM, mem_rvalid, mem_rdata,
    input  ready_w, RegWriteW, RdW, ResultW, retire_count
  );
endinterface

// File: rtl/writeback_stage_ld.sv
// Registered writeback stage with multi-cycle load completion and load extraction.
// Optional retired-instruction counter enabled by macro WB_RETIRE_COUNT_EN.
//
// state     | meaning
// IDLE      | accepting M-stage transfers, non-loads retire next edge
// WAIT_LOAD | load latched, stalled until mem_rvalid delivers the data
module writeback_stage_ld #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic                clock,
  input logic                reset,
  writeback_stage_ld_if.slave wb
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;

  logic [0:0]            state_q,    state_d;
  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] rd_q,       rd_d;
  logic [XLEN-1:0]       result_q,   result_d;
  logic [REG_ADDR_W-1:0] pend_rd_q,  pend_rd_d;
  logic                  pend_we_q,  pend_we_d;
  logic [2:0]            pend_f3_q,  pend_f3_d;
  logic [2:0]            pend_off_q, pend_off_d;

  logic                  accept;
  logic                  produce;
  logic [XLEN-1:0]       src_sel;
  logic [2:0]            off_eff;
  logic [XLEN-1:0]       sh_b, sh_h, sh_w;
  logic [XLEN-1:0]       load_ext;

  assign wb.ready_w = (state_q == IDLE);
  assign accept     = wb.valid_m && wb.ready_w;

  always_comb begin
    src_sel = wb.ALU_ResultM;
    case (wb.ResultSrcM)
      2'b10:   src_sel = wb.PCPlus4M;
      2'b11:   src_sel = wb.ImmExtM;
      default: src_sel = wb.ALU_ResultM;
    endcase
  end

  // On RV32 the doubleword offset bit has no meaning, so lanes wrap within 32 bits.
  assign off_eff = (XLEN == 64) ? pend_off_q : {1'b0, pend_off_q[1:0]};
  assign sh_b    = wb.mem_rdata >> {off_eff, 3'b000};
  assign sh_h    = wb.mem_rdata >> {off_eff[2:1], 4'b0000};
  assign sh_w    = (XLEN == 64) ? (wb.mem_rdata >> {off_eff[2], 5'b00000}) : wb.mem_rdata;

  always_comb begin
    load_ext = '0;
    case (pend_f3_q)
      3'b000:  load_ext = XLEN'($signed(sh_b[7:0]));
      3'b100:  load_ext = XLEN'(sh_b[7:0]);
      3'b001:  load_ext = XLEN'($signed(sh_h[15:0]));
      3'b101:  load_ext = XLEN'(sh_h[15:0]);
      3'b010:  load_ext = XLEN'($signed(sh_w[31:0]));
      3'b110:  load_ext = (XLEN == 64) ? XLEN'(sh_w[31:0]) : '0;
      3'b011:  load_ext = (XLEN == 64) ? wb.mem_rdata : '0;
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    result_d   = result_q;
    pend_rd_d  = pend_rd_q;
    pend_we_d  = pend_we_q;
    pend_f3_d  = pend_f3_q;
    pend_off_d = pend_off_q;
    produce    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wb.ResultSrcM == 2'b01) begin
            pend_rd_d  = wb.RdM;
            pend_we_d  = wb.RegWriteM;
            pend_f3_d  = wb.funct3M;
            pend_off_d = wb.ALU_ResultM[2:0];
            state_d    = WAIT_LOAD;
          end else begin
            result_d   = src_sel;
            rd_d       = wb.RdM;
            regwrite_d = wb.RegWriteM && (wb.RdM != '0);
            produce    = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (wb.mem_rvalid) begin
          result_d   = load_ext;
          rd_d       = pend_rd_q;
          regwrite_d = pend_we_q && (pend_rd_q != '0);
          produce    = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
      pend_rd_q  <= '0;
      pend_we_q  <= 1'b0;
      pend_f3_q  <= '0;
      pend_off_q <= '0;
    end else begin
      state_q    <= state_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      pend_rd_q  <= pend_rd_d;
      pend_we_q  <= pend_we_d;
      pend_f3_q  <= pend_f3_d;
      pend_off_q <= pend_off_d;
    end
  end

  assign wb.RegWriteW = regwrite_q;
  assign wb.RdW       = rd_q;
  assign wb.ResultW   = result_q;

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retire_q, retire_d;

  assign retire_d = produce ? retire_q + 64'd1 : retire_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) retire_q <= '0;
    else        retire_q <= retire_d;
  end

  assign wb.retire_count = retire_q;
`else
  logic unused_produce;
  assign unused_produce  = produce;
  assign wb.retire_count = '0;
`endif

endmodule

// File: tb/tb_writeback_stage_ld.sv
// Directed bench for writeback_stage_ld (RV32 build): ALU/PC+4/LUI writes, loads, reset.
module tb_writeback_stage_ld;
  localparam int XLEN = 32;
  localparam int RAW  = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  longint unsigned exp_retire = 0;

  writeback_stage_ld_if #(.XLEN(XLEN), .REG_ADDR_W(RAW)) wb ();

  writeback_stage_ld #(.XLEN(XLEN), .REG_ADDR_W(RAW)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [1:0] src, input logic [RAW-1:0] rd, input logic we,
                      input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                      input logic [31:0] exp_res, input string tag);
    @(negedge clock);
    wb.valid_m = 1'b1; wb.ResultSrcM = src; wb.RdM = rd; wb.RegWriteM = we;
    wb.ALU_ResultM = alu; wb.PCPlus4M = pc4; wb.ImmExtM = imm; wb.funct3M = 3'b000;
    @(posedge clock); #1;
    exp_retire++;
    chk({tag, "_we"},  64'(wb.RegWriteW), 64'(we && (rd != 0)));
    chk({tag, "_rd"},  64'(wb.RdW), 64'(rd));
    chk({tag, "_res"}, 64'(wb.ResultW), 64'(exp_res));
    chk({tag, "_rdy"}, 64'(wb.ready_w), 64'd1);
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    wb.valid_m = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [RAW-1:0] rd,
                      input logic [31:0] rdata, input int waits, input logic [31:0] exp_res,
                      input string tag);
    @(negedge clock);
    wb.valid_m = 1'b1; wb.ResultSrcM = 2'b01; wb.RdM = rd; wb.RegWriteM = 1'b1;
    wb.funct3M = f3; wb.ALU_ResultM = addr;
    @(posedge clock); #1;
    chk({tag, "_acc_we"},  64'(wb.RegWriteW), 64'd0);
    chk({tag, "_acc_rdy"}, 64'(wb.ready_w), 64'd0);
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      wb.valid_m = 1'b0;
      @(posedge clock); #1;
      chk({tag, "_wait_rdy"}, 64'(wb.ready_w), 64'd0);
      chk({tag, "_wait_we"},  64'(wb.RegWriteW), 64'd0);
    end
    @(negedge clock);
    wb.valid_m = 1'b0; wb.mem_rvalid = 1'b1; wb.mem_rdata = rdata;
    @(posedge clock); #1;
    exp_retire++;
    chk({tag, "_we"},  64'(wb.RegWriteW), 64'(rd != 0));
    chk({tag, "_rd"},  64'(wb.RdW), 64'(rd));
    chk({tag, "_res"}, 64'(wb.ResultW), 64'(exp_res));
    chk({tag, "_rdy"}, 64'(wb.ready_w), 64'd1);
    @(negedge clock);
    wb.mem_rvalid = 1'b0;
  endtask

  initial begin
    wb.valid_m = 0; wb.RegWriteM = 0; wb.RdM = '0; wb.ResultSrcM = 2'b00;
    wb.funct3M = 3'b000; wb.ALU_ResultM = '0; wb.PCPlus4M = '0; wb.ImmExtM = '0;
    wb.mem_rvalid = 0; wb.mem_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_we",  64'(wb.RegWriteW), 64'd0);
    chk("rst_rdy", 64'(wb.ready_w), 64'd1);
    @(negedge clock);
    reset = 1'b1;

    // Reset while a load is pending discards it.
    @(negedge clock);
    wb.valid_m = 1'b1; wb.ResultSrcM = 2'b01; wb.RdM = 5'd9; wb.RegWriteM = 1'b1;
    wb.ALU_ResultM = 32'h10;
    @(posedge clock); #1;
    chk("pre_rst_rdy", 64'(wb.ready_w), 64'd0);
    @(negedge clock);
    wb.valid_m = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_rdy", 64'(wb.ready_w), 64'd1);
    chk("midrst_we",  64'(wb.RegWriteW), 64'd0);
    chk("midrst_rd",  64'(wb.RdW), 64'd0);
    chk("midrst_res", 64'(wb.ResultW), 64'd0);
    chk("midrst_cnt", wb.retire_count, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    wb.mem_rvalid = 1'b1; wb.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    chk("stale_rv_we",  64'(wb.RegWriteW), 64'd0);
    chk("stale_rv_res", 64'(wb.ResultW), 64'd0);
    @(negedge clock);
    wb.mem_rvalid = 1'b0;

    // Back-to-back non-load transfers.
    xfer(2'b00, 5'd5, 1'b1, 32'h0000_1234, 32'h0,   32'h0,         32'h0000_1234, "alu");
    xfer(2'b10, 5'd6, 1'b1, 32'h0,         32'h104, 32'h0,         32'h0000_0104, "pc4");
    xfer(2'b11, 5'd8, 1'b1, 32'h0,         32'h0,   32'hABCD_E000, 32'hABCD_E000, "lui");
    xfer(2'b00, 5'd3, 1'b0, 32'h0000_0077, 32'h0,   32'h0,         32'h0000_0077, "nowe");
    idle_cycle();
    chk("idle_we",  64'(wb.RegWriteW), 64'd0);
    chk("idle_rd",  64'(wb.RdW), 64'd3);
    chk("idle_res", 64'(wb.ResultW), 64'h77);

    // Loads: 3 idle cycles before data on the first, varied waits elsewhere.
    load(3'b000, 32'h0000_1003, 5'd7,  32'h80FF_0000, 3, 32'hFFFF_FF80, "lb");
    load(3'b100, 32'h0000_1003, 5'd7,  32'h80FF_0000, 3, 32'h0000_0080, "lbu");
    load(3'b000, 32'h0000_1001, 5'd10, 32'h80FF_7F00, 0, 32'h0000_007F, "lb1");
    load(3'b001, 32'h0000_2002, 5'd11, 32'h8001_1234, 1, 32'hFFFF_8001, "lh");
    load(3'b101, 32'h0000_2002, 5'd11, 32'h8001_1234, 2, 32'h0000_8001, "lhu");
    load(3'b001, 32'h0000_2003, 5'd12, 32'h8001_1234, 0, 32'hFFFF_8001, "lh_odd");
    load(3'b001, 32'h0000_2000, 5'd12, 32'h8001_9234, 0, 32'hFFFF_9234, "lh_lo");
    load(3'b010, 32'h0000_3006, 5'd13, 32'hCAFE_BABE, 1, 32'hCAFE_BABE, "lw");
    load(3'b111, 32'h0000_3000, 5'd14, 32'hCAFE_BABE, 0, 32'h0000_0000, "bad_f3");
    load(3'b000, 32'h0000_0002, 5'd0,  32'h0055_0000, 0, 32'h0000_0055, "lb_rd0");

    xfer(2'b00, 5'd0, 1'b1, 32'h0000_DEAD, 32'h0, 32'h0, 32'h0000_DEAD, "rd0");

`ifdef WB_RETIRE_COUNT_EN
    chk("retire", wb.retire_count, 64'(exp_retire));
`else
    chk("retire", wb.retire_count, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
